// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: a byte FIFO feeding an 11-bit frame serialiser
// (start 0, data LSB first, odd parity, stop 1) on idle-high ps2_clk/ps2_data.
module ps2_device_tx #(
   parameter int CLK_DIV    = 4,
   parameter int GAP        = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy
);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_INC  = CW'(1);
   localparam logic [AW:0]   FILL_MAX = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   FILL_NIL = {(AW + 1){1'b0}};
   localparam logic [AW-1:0] PTR_INC  = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit_idx;
   logic [10:0]   r_frame;
   logic          r_ps2_clk;
   logic          r_ps2_data;
   logic          r_busy;

   state_t        w_state_next;
   logic [CW-1:0] w_cnt_next;
   logic [3:0]    w_idx_next;
   logic [AW:0]   w_count_next;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_line_data;
   logic [7:0]    w_head;

   assign w_full   = (r_count == FILL_MAX);
   assign w_push   = in_valid && !w_full;
   assign w_head   = r_mem[r_rd_ptr];
   assign in_ready = !w_full;
   assign ps2_clk  = r_ps2_clk;
   assign ps2_data = r_ps2_data;
   assign busy     = r_busy;

   // FIFO occupancy after this edge's push and pop
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + FILL_ONE;
         2'b01:   w_count_next = r_count - FILL_ONE;
         default: w_count_next = r_count;
      endcase
   end

   // FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            r_mem[k] <= 8'h00;
         end
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= FILL_NIL;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + PTR_INC;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_INC;
         end
         r_count <= w_count_next;
      end
   end

   // Frame sequencer next-state: each bit is a HIGH then a LOW phase of CLK_DIV cycles
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_bit_idx;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count != FILL_NIL) begin
               w_pop        = 1'b1;
               w_state_next = ST_HIGH;
               w_cnt_next   = CNT_ZERO;
               w_idx_next   = 4'd0;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (r_cnt == DIV_LAST) begin
               w_state_next = ST_LOW;
               w_cnt_next   = CNT_ZERO;
            end else begin
               w_cnt_next = r_cnt + CNT_INC;
            end
         end
         ST_LOW: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt_next = CNT_ZERO;
               if (r_bit_idx < 4'd10) begin
                  w_idx_next   = r_bit_idx + 4'd1;
                  w_state_next = ST_HIGH;
               end else begin
                  w_state_next = ST_GAP;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_INC;
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = CNT_ZERO;
            end else begin
               w_cnt_next = r_cnt + CNT_INC;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = CNT_ZERO;
            w_idx_next   = 4'd0;
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= CNT_ZERO;
         r_bit_idx <= 4'd0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_idx_next;
      end
   end

   // Frame is built once at pop time so parity depends only on the popped byte
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_frame <= 11'h000;
      end else if (w_pop) begin
         r_frame <= {1'b1, odd_parity(w_head), w_head, 1'b0};
      end else begin
         r_frame <= r_frame;
      end
   end

   // Line value implied by the current state; data only moves when a HIGH phase starts
   always_comb begin
      w_line_data = 1'b1;
      case (r_state)
         ST_HIGH: w_line_data = r_frame[r_bit_idx];
         ST_LOW:  w_line_data = r_frame[r_bit_idx];
         default: w_line_data = 1'b1;
      endcase
   end

   // Registered pins; busy looks ahead so it tracks occupancy and state without lag
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ps2_clk  <= 1'b1;
         r_ps2_data <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_ps2_clk  <= (r_state != ST_LOW);
         r_ps2_data <= w_line_data;
         r_busy     <= (w_count_next != FILL_NIL) || (w_state_next != ST_IDLE);
      end
   end

endmodule
